// File: rtl/vga_pkg.sv
// Shared raster timing constants and coordinate type for the VGA display path.
package vga_pkg;

  localparam int H_VISIBLE    = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_VISIBLE    = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Screen coordinate shared by every renderer (DrawX / DrawY).
  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus in-window flags that are
// registered from the next count, so they line up with the count they describe.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752,
  parameter int TOTAL      = 800
) (
  input  logic   vga_clk,
  input  logic   reset,
  input  logic   restart,   // force the next count to 0 (first cycle after reset)
  input  logic   en,        // advance one position
  output coord_t cnt,
  output logic   tc,        // current count is the last position of the axis
  output logic   in_vis,
  output logic   in_sync
);

  coord_t cnt_nxt;

  assign tc = (cnt == coord_t'(TOTAL - 1));

  // Next position: restart dominates, otherwise wrap at the terminal count.
  always_comb begin
    cnt_nxt = cnt;
    if (restart)
      cnt_nxt = '0;
    else if (en)
      cnt_nxt = tc ? '0 : cnt + coord_t'(1);
  end

  // Count and window flags advance together so they never skew.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      cnt     <= '0;
      in_vis  <= 1'b0;
      in_sync <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      in_vis  <= (cnt_nxt < coord_t'(VISIBLE));
      in_sync <= (cnt_nxt >= coord_t'(SYNC_START)) && (cnt_nxt < coord_t'(SYNC_END));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source: DrawX/DrawY, active-low syncs, blank
// (1 = visible) and frame/line pulses, all registered and coincident.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic   vga_clk,
  input  logic   reset,
  output logic   hs,
  output logic   vs,
  output logic   blank,
  output logic   sync,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   frame_start,
  output logic   line_end
);

  localparam int H_TOT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SS   = H_VISIBLE + H_FRONT;
  localparam int V_SS   = V_VISIBLE + V_FRONT;

  logic run;
  logic h_tc, h_vis, h_sync;
  logic v_tc, v_vis, v_sync;

  vga_axis_counter #(
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_SS),
    .SYNC_END   (H_SS + H_SYNC),
    .TOTAL      (H_TOT)
  ) u_h (
    .vga_clk (vga_clk),
    .reset   (reset),
    .restart (~run),
    .en      (1'b1),
    .cnt     (DrawX),
    .tc      (h_tc),
    .in_vis  (h_vis),
    .in_sync (h_sync)
  );

  // Vertical axis steps only when the horizontal axis wraps, so both wrap together at frame end.
  vga_axis_counter #(
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_SS),
    .SYNC_END   (V_SS + V_SYNC),
    .TOTAL      (V_TOT)
  ) u_v (
    .vga_clk (vga_clk),
    .reset   (reset),
    .restart (~run),
    .en      (h_tc),
    .cnt     (DrawY),
    .tc      (v_tc),
    .in_vis  (v_vis),
    .in_sync (v_sync)
  );

  // run is low only on the first edge after reset, holding the raster at (0,0) for that cycle;
  // the pulses are registered from where the raster will be next.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      run         <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else begin
      run         <= 1'b1;
      frame_start <= ~run | (h_tc & v_tc);
      line_end    <= run & (DrawX == coord_t'(H_TOT - 2));
    end
  end

  assign hs    = ~h_sync;
  assign vs    = ~v_sync;
  assign blank = h_vis & v_vis;
  assign sync  = 1'b0;

endmodule
